mestpro_mem_ctrl: RTL

//  Request front-end that sits directly upstream of the MESTPro memory and owns its addr/in_dat/WE/CS pins.

---
 rtl/mestpro_mem_ctrl_pkg.sv | 31 +++
 rtl/mestpro_mem_ctrl_if.sv | 34 +++
 rtl/mestpro_mem_ctrl_req_fifo.sv | 43 ++++
 rtl/mestpro_mem_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mestpro_mem_ctrl_pkg.sv
// rtl/mestpro_mem_ctrl_pkg.sv - shared widths, FSM encoding and request record for the MESTPro memory front-end
package mestpro_mem_ctrl_pkg;

  localparam int ADDR_BITS = 8;
  localparam int DATA_BITS = 8;

  // Wide enough for RD_LAT-1 with RD_LAT up to 7
  localparam int LAT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_VRD   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  typedef struct packed {
    logic                 we;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
  } req_t;

  localparam int REQ_W = 1 + ADDR_BITS + DATA_BITS;

  // Load value for the wait counter: it counts down to zero, so the last wait cycle sees 0
  function automatic logic [LAT_W-1:0] lat_init(input int rd_lat);
    return LAT_W'(rd_lat - 1);
  endfunction

endpackage

// File: rtl/mestpro_mem_ctrl_if.sv
// rtl/mestpro_mem_ctrl_if.sv - request/response ports and memory pins of the MESTPro memory front-end
interface mestpro_mem_ctrl_if;
  import mestpro_mem_ctrl_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [ADDR_BITS-1:0] req_addr;
  logic [DATA_BITS-1:0] req_wdata;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DATA_BITS-1:0] rsp_rdata;
  logic                 rsp_err;

  logic [ADDR_BITS-1:0] addr;
  logic [DATA_BITS-1:0] in_dat;
  logic                 WE;
  logic                 CS;
  logic [DATA_BITS-1:0] o_dat;

  // Controller side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, o_dat,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, addr, in_dat, WE, CS
  );

  // Requester plus memory side
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, o_dat,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, addr, in_dat, WE, CS
  );

endinterface

// File: rtl/mestpro_mem_ctrl_req_fifo.sv
// rtl/mestpro_mem_ctrl_req_fifo.sv - first-word-fall-through request FIFO with wrap-bit pointers
module mestpro_req_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage write; a push while full is only issued together with a pop of the same slot
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/mestpro_mem_ctrl.sv
// rtl/mestpro_mem_ctrl.sv - MESTPro memory request front-end; MESTPRO_MEMCTRL_WRCHK_EN adds write read-back verify
module mestpro_mem_ctrl
  import mestpro_mem_ctrl_pkg::*;
#(
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  mestpro_mem_ctrl_if.slave   bus
);

  state_t               state;
  state_t               next_state;

  logic [REQ_W-1:0]     fifo_wdata;
  logic [REQ_W-1:0]     fifo_rdata;
  req_t                 head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;

  logic                 op_we;
  logic [LAT_W-1:0]     lat_cnt;

  logic                 cs_q;
  logic                 we_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] in_dat_q;
  logic                 rsp_valid_q;
  logic [DATA_BITS-1:0] rsp_rdata_q;

  // The head is consumed on the IDLE cycle that launches its access
  assign pop  = (state == ST_IDLE) && !fifo_empty;

  // A full FIFO still accepts when the head leaves in the same cycle
  assign bus.req_ready = !RESET && (!fifo_full || pop);
  assign push          = bus.req_valid && bus.req_ready;

  assign fifo_wdata = {bus.req_we, bus.req_addr, bus.req_wdata};
  assign head       = fifo_rdata;

  mestpro_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= next_state;
  end

  // FSM next state: one access in flight, reads wait out the memory latency
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (!fifo_empty) next_state = ST_ISSUE;
      ST_ISSUE: begin
        if (!op_we) begin
          next_state = ST_WAIT;
        end else begin
`ifdef MESTPRO_MEMCTRL_WRCHK_EN
          next_state = ST_VRD;
`else
          next_state = ST_IDLE;
`endif
        end
      end
`ifdef MESTPRO_MEMCTRL_WRCHK_EN
      ST_VRD:   next_state = ST_WAIT;
`endif
      ST_WAIT:  if (lat_cnt == '0) next_state = ST_RESP;
      ST_RESP:  if (bus.rsp_ready) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Remember the kind of the popped request for the rest of its sequence
  always_ff @(posedge CLK) begin
    if (RESET)    op_we <= 1'b0;
    else if (pop) op_we <= head.we;
  end

  // Registered memory pins; addr/in_dat only change when a new request is launched
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      in_dat_q <= '0;
    end else begin
      cs_q <= (next_state == ST_ISSUE) || (next_state == ST_VRD);
      we_q <= (next_state == ST_ISSUE) && head.we;
      if (pop) begin
        addr_q   <= head.addr;
        in_dat_q <= head.wdata;
      end
    end
  end

  // Read latency countdown, loaded on entry to WAIT
  always_ff @(posedge CLK) begin
    if (RESET) begin
      lat_cnt <= '0;
    end else if ((next_state == ST_WAIT) && (state != ST_WAIT)) begin
      lat_cnt <= lat_init(RD_LAT);
    end else if ((state == ST_WAIT) && (lat_cnt != '0)) begin
      lat_cnt <= lat_cnt - LAT_W'(1);
    end
  end

  // Response register: capture o_dat on the last wait cycle, hold until accepted
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else if ((state == ST_WAIT) && (lat_cnt == '0)) begin
      rsp_valid_q <= 1'b1;
      rsp_rdata_q <= bus.o_dat;
    end else if ((state == ST_RESP) && bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

`ifdef MESTPRO_MEMCTRL_WRCHK_EN
  logic [DATA_BITS-1:0] wdata_q;
  logic                 rsp_err_q;

  // Written value kept for comparison against the read-back
  always_ff @(posedge CLK) begin
    if (RESET)    wdata_q <= '0;
    else if (pop) wdata_q <= head.wdata;
  end

  // Verify status, produced alongside the read-back data
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rsp_err_q <= 1'b0;
    end else if ((state == ST_WAIT) && (lat_cnt == '0)) begin
      rsp_err_q <= op_we && (bus.o_dat != wdata_q);
    end
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.CS        = cs_q;
  assign bus.WE        = we_q;
  assign bus.addr      = addr_q;
  assign bus.in_dat    = in_dat_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule
